rob_commit: RTL and testbench

In-order retirement unit at the ROB head; it is the consumer of the per-entry deq port.
- Each cycle it inspects the COMMIT_WIDTH oldest entries and picks the longest in-order prefix that is complete.
- It drives the per-entry commit strobes and advances the head pointer.
- Its registered side effects release old physical registers to the freelist and update the architectural rename table.

---
 rtl/rob_commit_pkg.sv | 32 +++
 rtl/commit_prefix_sel.sv | 30 +++
 rtl/rob_commit.sv | 139 +++++++++++++
 tb/tb_rob_commit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared definitions for the ROB retirement stage: commit FSM states, default sizes
// and the PC / logical / physical register widths taken from the `*_RANGE macros.
`ifndef PC_RANGE
`define PC_RANGE 39:0
`endif
`ifndef LREG_RANGE
`define LREG_RANGE 4:0
`endif
`ifndef PREG_RANGE
`define PREG_RANGE 6:0
`endif

package rob_commit_pkg;

    typedef enum logic [1:0] {
        RUN,
        BLOCK,
        RECOVER
    } commit_state_t;

    localparam int COMMIT_WIDTH_DEF = 2;
    localparam int ROB_DEPTH_DEF    = 64;

    typedef logic [`PC_RANGE]   pc_t;
    typedef logic [`LREG_RANGE] lreg_t;
    typedef logic [`PREG_RANGE] preg_t;

    localparam int PC_W   = $bits(pc_t);
    localparam int LREG_W = $bits(lreg_t);
    localparam int PREG_W = $bits(preg_t);

endpackage

// File: rtl/commit_prefix_sel.sv
// In-order prefix selector: marks the leading run of set bits in 'ready' and counts it.
// Shared by retirement and by the flush-walk logic.
module commit_prefix_sel
    import rob_commit_pkg::*;
#(
    parameter int WIDTH = COMMIT_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] ready,
    input  logic             enable,
    output logic [WIDTH-1:0] mask,
    output logic [CNT_W-1:0] count
);

    // The first zero in 'ready' kills every slot above it.
    always_comb begin
        logic alive;
        alive = enable;
        mask  = '0;
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alive   = alive & ready[i];
            mask[i] = alive;
            if (alive) begin
                count = count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement at the ROB head: commits the complete prefix, advances head_ptr,
// and registers freelist releases and arch-RAT writes. Optional: COMMIT_DIFFTEST_EN.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
    parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
    parameter int PTR_W        = $clog2(ROB_DEPTH)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [COMMIT_WIDTH-1:0]              head_deq,
    input  logic [COMMIT_WIDTH-1:0][PC_W-1:0]    head_pc,
    input  logic [COMMIT_WIDTH-1:0][31:0]        head_instr,
    input  logic [COMMIT_WIDTH-1:0][LREG_W-1:0]  head_lrd,
    input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  head_prd,
    input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  head_old_prd,
    input  logic [COMMIT_WIDTH-1:0]              head_need_to_wb,
    input  logic [COMMIT_WIDTH-1:0]              head_skip,
    input  logic                                 flush,
    input  logic                                 fl_ready,
    output logic [COMMIT_WIDTH-1:0]              commit,
    output logic [PTR_W:0]                       head_ptr,
    output logic [COMMIT_WIDTH-1:0]              fl_rel_valid,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  fl_rel_preg,
    output logic [COMMIT_WIDTH-1:0]              arat_we,
    output logic [COMMIT_WIDTH-1:0][LREG_W-1:0]  arat_lrd,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  arat_prd,
`ifdef COMMIT_DIFFTEST_EN
    output logic [COMMIT_WIDTH-1:0]              dt_valid,
    output logic [COMMIT_WIDTH-1:0][PC_W-1:0]    dt_pc,
    output logic [COMMIT_WIDTH-1:0][31:0]        dt_instr,
    output logic [COMMIT_WIDTH-1:0]              dt_skip,
    output logic [COMMIT_WIDTH-1:0][LREG_W-1:0]  dt_lrd,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  dt_prd,
`endif
    output logic [63:0]                          retire_cnt,
    output logic [31:0]                          stall_cnt
);

    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    commit_state_t           state;
    logic                    commit_en;
    logic [CNT_W-1:0]        commit_n;
    logic [COMMIT_WIDTH-1:0] release_vec;
    logic [64:0]             retire_sum;

    assign commit_en = (state == RUN) & fl_ready & ~flush & ~reset;

    commit_prefix_sel #(
        .WIDTH (COMMIT_WIDTH),
        .CNT_W (CNT_W)
    ) u_prefix (
        .ready  (head_deq),
        .enable (commit_en),
        .mask   (commit),
        .count  (commit_n)
    );

    // Writes to x0 neither free a register nor touch the arch-RAT.
    always_comb begin
        release_vec = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            release_vec[i] = commit[i] & head_need_to_wb[i] & (head_lrd[i] != '0);
        end
    end

    assign retire_sum = {1'b0, retire_cnt} + 65'(commit_n);

    // Same-lrd writes in one cycle both issue; the arch-RAT lets the higher slot win.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            head_ptr     <= '0;
            fl_rel_valid <= '0;
            fl_rel_preg  <= '0;
            arat_we      <= '0;
            arat_lrd     <= '0;
            arat_prd     <= '0;
            retire_cnt   <= '0;
            stall_cnt    <= '0;
        end else begin
            fl_rel_valid <= release_vec;
            fl_rel_preg  <= head_old_prd;
            arat_we      <= release_vec;
            arat_lrd     <= head_lrd;
            arat_prd     <= head_prd;
            retire_cnt   <= retire_sum[64] ? '1 : retire_sum[63:0];
            if (flush) begin
                head_ptr <= '0;
                state    <= RECOVER;
            end else begin
                head_ptr <= head_ptr + (PTR_W + 1)'(commit_n);
                case (state)
                    RUN: begin
                        if (head_deq[0] && !fl_ready) begin
                            state <= BLOCK;
                        end
                    end
                    BLOCK: begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 32'd1;
                        end
                        if (fl_ready) begin
                            state <= RUN;
                        end
                    end
                    RECOVER: state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

`ifdef COMMIT_DIFFTEST_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            dt_valid <= '0;
            dt_pc    <= '0;
            dt_instr <= '0;
            dt_skip  <= '0;
            dt_lrd   <= '0;
            dt_prd   <= '0;
        end else begin
            dt_valid <= commit;
            dt_pc    <= head_pc;
            dt_instr <= head_instr;
            dt_skip  <= head_skip;
            dt_lrd   <= head_lrd;
            dt_prd   <= head_prd;
        end
    end
`else
    logic unused_difftest;
    assign unused_difftest = ^{head_pc, head_instr, head_skip};
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a queue-based reference model predicts commit strobes
// and the registered outputs; a negedge monitor pops and compares.
module tb_rob_commit;
    import rob_commit_pkg::*;

    localparam int CW    = COMMIT_WIDTH_DEF;
    localparam int DEPTH = ROB_DEPTH_DEF;

    logic                          clock;
    logic                          reset;
    logic [CW-1:0]                 head_deq;
    logic [CW-1:0][PC_W-1:0]       head_pc;
    logic [CW-1:0][31:0]           head_instr;
    logic [CW-1:0][LREG_W-1:0]     head_lrd;
    logic [CW-1:0][PREG_W-1:0]     head_prd;
    logic [CW-1:0][PREG_W-1:0]     head_old_prd;
    logic [CW-1:0]                 head_need_to_wb;
    logic [CW-1:0]                 head_skip;
    logic                          flush;
    logic                          fl_ready;
    logic [CW-1:0]                 commit;
    logic [6:0]                    head_ptr;
    logic [CW-1:0]                 fl_rel_valid;
    logic [CW-1:0][PREG_W-1:0]     fl_rel_preg;
    logic [CW-1:0]                 arat_we;
    logic [CW-1:0][LREG_W-1:0]     arat_lrd;
    logic [CW-1:0][PREG_W-1:0]     arat_prd;
    logic [63:0]                   retire_cnt;
    logic [31:0]                   stall_cnt;

    rob_commit dut (
        .clock           (clock),
        .reset           (reset),
        .head_deq        (head_deq),
        .head_pc         (head_pc),
        .head_instr      (head_instr),
        .head_lrd        (head_lrd),
        .head_prd        (head_prd),
        .head_old_prd    (head_old_prd),
        .head_need_to_wb (head_need_to_wb),
        .head_skip       (head_skip),
        .flush           (flush),
        .fl_ready        (fl_ready),
        .commit          (commit),
        .head_ptr        (head_ptr),
        .fl_rel_valid    (fl_rel_valid),
        .fl_rel_preg     (fl_rel_preg),
        .arat_we         (arat_we),
        .arat_lrd        (arat_lrd),
        .arat_prd        (arat_prd),
        .retire_cnt      (retire_cnt),
        .stall_cnt       (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]              head;
        logic [CW-1:0]           rel;
        logic [CW-1:0][PREG_W-1:0] rel_preg;
        logic [CW-1:0][LREG_W-1:0] lrd;
        logic [CW-1:0][PREG_W-1:0] prd;
        logic [63:0]             retire;
        logic [31:0]             stall;
    } reg_exp_t;

    logic [CW-1:0] comb_q[$];
    reg_exp_t      reg_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: head as an integer modulo 2*DEPTH, modes as two flags.
    int          m_head = 0;
    longint unsigned m_retire = 0;
    int unsigned m_stall = 0;
    bit          m_blocked = 0;
    bit          m_recovering = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic randomizePayload();
        for (int i = 0; i < CW; i++) begin
            head_pc[i]         = PC_W'({$urandom(), $urandom()});
            head_instr[i]      = $urandom();
            head_lrd[i]        = LREG_W'($urandom_range(0, 7));
            head_prd[i]        = PREG_W'($urandom());
            head_old_prd[i]    = PREG_W'($urandom());
            head_need_to_wb[i] = 1'($urandom_range(0, 1));
            head_skip[i]       = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit [CW-1:0] deq, input bit flr, input bit fl);
        logic [CW-1:0] exp_commit;
        reg_exp_t      e;
        int            n;
        bit            open;
        reset    = rst;
        head_deq = deq;
        fl_ready = flr;
        flush    = fl;
        exp_commit = '0;
        n = 0;
        open = !rst && !fl && flr && !m_blocked && !m_recovering;
        for (int i = 0; i < CW; i++) begin
            open = open && deq[i];
            if (open) begin
                exp_commit[i] = 1'b1;
                n++;
            end
        end
        comb_q.push_back(exp_commit);
        e.rel      = '0;
        e.rel_preg = head_old_prd;
        e.lrd      = head_lrd;
        e.prd      = head_prd;
        if (rst) begin
            m_head = 0;
            m_retire = 0;
            m_stall = 0;
            m_blocked = 0;
            m_recovering = 0;
        end else begin
            for (int i = 0; i < CW; i++)
                e.rel[i] = exp_commit[i] && head_need_to_wb[i] && (head_lrd[i] != 0);
            if (m_retire > 64'hFFFF_FFFF_FFFF_FFFF - longint'(n)) m_retire = 64'hFFFF_FFFF_FFFF_FFFF;
            else m_retire = m_retire + longint'(n);
            if (m_blocked && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
            m_head = fl ? 0 : (m_head + n) % (2 * DEPTH);
            if (fl) begin
                m_recovering = 1;
                m_blocked = 0;
            end else if (m_recovering) begin
                m_recovering = 0;
            end else if (m_blocked) begin
                m_blocked = !flr;
            end else begin
                m_blocked = deq[0] && !flr;
            end
        end
        e.head   = 7'(m_head);
        e.retire = m_retire;
        e.stall  = m_stall;
        @(posedge clock);
        #1;
        reg_q.push_back(e);
    endtask

    // Monitor: compares whatever the model has queued for this point in the cycle.
    initial begin
        logic [CW-1:0] c;
        reg_exp_t      e;
        forever begin
            @(negedge clock);
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                checkOutput("commit", 64'(commit), 64'(c));
            end
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                checkOutput("head_ptr", 64'(head_ptr), 64'(e.head));
                checkOutput("fl_rel_valid", 64'(fl_rel_valid), 64'(e.rel));
                checkOutput("arat_we", 64'(arat_we), 64'(e.rel));
                checkOutput("retire_cnt", retire_cnt, e.retire);
                checkOutput("stall_cnt", 64'(stall_cnt), 64'(e.stall));
                for (int i = 0; i < CW; i++) begin
                    if (e.rel[i]) begin
                        checkOutput($sformatf("fl_rel_preg[%0d]", i), 64'(fl_rel_preg[i]), 64'(e.rel_preg[i]));
                        checkOutput($sformatf("arat_lrd[%0d]", i), 64'(arat_lrd[i]), 64'(e.lrd[i]));
                        checkOutput($sformatf("arat_prd[%0d]", i), 64'(arat_prd[i]), 64'(e.prd[i]));
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fl_ready = 1'b0;
        head_deq = '0;
        randomizePayload();
        @(posedge clock);
        #1;

        repeat (3) applyStimulus(1, 2'b11, 1, 0);

        head_need_to_wb = 2'b11;
        head_lrd[0] = 5;
        head_lrd[1] = 7;
        head_old_prd[0] = 12;
        head_old_prd[1] = 20;
        applyStimulus(0, 2'b11, 1, 0);

        applyStimulus(0, 2'b10, 1, 0);
        applyStimulus(0, 2'b01, 1, 0);

        repeat (4) applyStimulus(0, 2'b01, 0, 0);
        applyStimulus(0, 2'b01, 1, 0);
        applyStimulus(0, 2'b01, 1, 0);

        applyStimulus(0, 2'b11, 1, 1);
        repeat (2) applyStimulus(0, 2'b11, 1, 0);

        // Walk the head to 63, then retire two to cross the wrap boundary.
        applyStimulus(0, 2'b00, 1, 1);
        applyStimulus(0, 2'b00, 1, 0);
        repeat (31) applyStimulus(0, 2'b11, 1, 0);
        applyStimulus(0, 2'b01, 1, 0);
        applyStimulus(0, 2'b11, 1, 0);

        for (int k = 0; k < 3000; k++) begin
            randomizePayload();
            applyStimulus($urandom_range(0, 199) == 0, CW'($urandom()),
                          $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0);
        end

        @(negedge clock);
        #1;
        checkOutput("drain", 64'(comb_q.size() + reg_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
